mem_responder: RTL

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 120 ++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// Byte-addressed memory slave with MOV/MOC handshake and a fixed WAIT_CYCLES latency.
// Define MEM_ALIGN_CHECK_EN to flag misaligned word accesses on ERR instead of aligning them.
module mem_responder #(
   parameter int ADDR_W      = 8,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              CLK,
   input  logic              CLR,
   input  logic              MOV,
   input  logic              RW,
   input  logic              typeData,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       dataIn,
   output logic [31:0]       dataOut,
   output logic              MOC
`ifdef MEM_ALIGN_CHECK_EN
   ,
   output logic              ERR
`endif
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t            state_q;
   logic [3:0]        cnt_q;
   logic              rw_q;
   logic              word_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic [31:0]       dout_q;
   logic              moc_q;
   logic [7:0]        mem [2**ADDR_W];

   logic [ADDR_W-1:0] b0_d, b1_d, b2_d, b3_d;
   logic [31:0]       rdata_d;
   logic              misalign_d;
   logic              fire_d;

   // Word accesses use the aligned base, so b1..b3 never carry past the top of memory.
   assign b0_d = word_q ? {addr_q[ADDR_W-1:2], 2'b00} : addr_q;
   assign b1_d = b0_d | ADDR_W'(1);
   assign b2_d = b0_d | ADDR_W'(2);
   assign b3_d = b0_d | ADDR_W'(3);

   assign rdata_d = word_q ? {mem[b0_d], mem[b1_d], mem[b2_d], mem[b3_d]}
                           : {24'b0, mem[b0_d]};

`ifdef MEM_ALIGN_CHECK_EN
   assign misalign_d = word_q && (addr_q[1:0] != 2'b00);
`else
   assign misalign_d = 1'b0;
`endif

   // The single edge on which the latched access takes effect.
   assign fire_d = !CLR && (state_q == BUSY) && MOV && (cnt_q == 4'(WAIT_CYCLES));

   always_ff @(posedge CLK) begin
      if (fire_d && !rw_q && !misalign_d) begin
         if (word_q) begin
            mem[b0_d] <= wdata_q[31:24];
            mem[b1_d] <= wdata_q[23:16];
            mem[b2_d] <= wdata_q[15:8];
            mem[b3_d] <= wdata_q[7:0];
         end else begin
            mem[b0_d] <= wdata_q[7:0];
         end
      end
   end

   // BUSY is always entered, even for WAIT_CYCLES=0, so MOC rises WAIT_CYCLES+1 edges after the request.
   always_ff @(posedge CLK) begin
      if (CLR) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         moc_q   <= 1'b0;
         dout_q  <= 32'd0;
      end else begin
         case (state_q)
            IDLE: if (MOV) begin
               rw_q    <= RW;
               word_q  <= typeData;
               addr_q  <= addr;
               wdata_q <= dataIn;
               cnt_q   <= 4'd0;
               state_q <= BUSY;
            end
            BUSY: begin
               if (!MOV) begin
                  state_q <= IDLE;
               end else if (cnt_q == 4'(WAIT_CYCLES)) begin
                  state_q <= DONE;
                  moc_q   <= 1'b1;
                  if (rw_q && !misalign_d) dout_q <= rdata_d;
               end else begin
                  cnt_q <= cnt_q + 4'd1;
               end
            end
            DONE: if (!MOV) begin
               state_q <= IDLE;
               moc_q   <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef MEM_ALIGN_CHECK_EN
   logic err_q;
   always_ff @(posedge CLK) begin
      if (CLR)                              err_q <= 1'b0;
      else if (fire_d)                      err_q <= misalign_d;
      else if (state_q == DONE && !MOV)     err_q <= 1'b0;
   end
   assign ERR = err_q;
`endif

   assign dataOut = dout_q;
   assign MOC     = moc_q;

endmodule
